// File: rtl/audio_clk_pkg.sv
// Shared constants for the audio bit-clock / word-select generator.
package audio_clk_pkg;
  localparam int AC_DIV_W        = 8;
  localparam int AC_LR_W         = 6;
  localparam int AC_DEF_BCLK_DIV = 4;
  localparam int AC_DEF_LR_DIV   = 32;
  localparam int AC_MIN_BCLK_DIV = 2;
  localparam int AC_MIN_LR_DIV   = 1;
endpackage

// File: rtl/audio_clk_gen_clk_div_core.sv
// Programmable divider stage: wrapping counter with a registered level and
// rise/fall strobes. Threshold mode for BCLK duty, toggle-on-wrap for LRCLK.
module clk_div_core
  import audio_clk_pkg::*;
#(
  parameter int W         = AC_DIV_W,
  parameter int MIN_RATIO = AC_MIN_BCLK_DIV,
  parameter bit TOGGLE    = 1'b0
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         run,
  input  logic         advance,
  input  logic [W-1:0] ratio,
  output logic         level,
  output logic         rise,
  output logic         fall,
  output logic         fall_next
);
  localparam logic [W-1:0] MIN_W = W'(MIN_RATIO);

  logic [W-1:0] cnt_q, cnt_d, r_eff, half, last;
  logic         level_q, level_d, rise_q, rise_d, fall_q, fall_d, wrap;

  always_comb begin
    r_eff   = (ratio < MIN_W) ? MIN_W : ratio;
    half    = (r_eff >> 1) + {{(W-1){1'b0}}, r_eff[0]};
    last    = r_eff - W'(1);
    wrap    = (cnt_q == last);
    cnt_d   = cnt_q;
    level_d = level_q;
    if (!run) begin
      cnt_d   = '0;
      level_d = 1'b0;
    end else if (advance) begin
      cnt_d = wrap ? '0 : cnt_q + W'(1);
      // level tracks the new count so it changes in the same cycle as cnt
      if (TOGGLE) level_d = wrap ? ~level_q : level_q;
      else        level_d = (cnt_d >= half);
    end
    rise_d = run & level_d & ~level_q;
    fall_d = run & ~level_d & level_q;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level     = level_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign fall_next = fall_d;
endmodule

// File: rtl/audio_clk_gen.sv
// I2S-style clock generator: BCLK divided from clk_in, LRCLK divided from
// BCLK falling edges, ratios double-buffered and swapped at frame boundaries.
module audio_clk_gen
  import audio_clk_pkg::*;
#(
  parameter int DIV_W        = AC_DIV_W,
  parameter int LR_W         = AC_LR_W,
  parameter int DEF_BCLK_DIV = AC_DEF_BCLK_DIV,
  parameter int DEF_LR_DIV   = AC_DEF_LR_DIV
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [DIV_W-1:0] div_bclk,
  input  logic [LR_W-1:0]  div_lr,
  output logic             bclk_out,
  output logic             bclk_rise,
  output logic             bclk_fall,
  output logic             lrclk_out,
  output logic             frame_start
);
  logic [DIV_W-1:0] shd_bclk_q, shd_bclk_d, act_bclk_q, act_bclk_d;
  logic [LR_W-1:0]  shd_lr_q, shd_lr_d, act_lr_q, act_lr_d;
  logic             apply, bclk_fall_next, lr_rise_unused, lr_fall_next_unused;

  // The active ratio fed to the cores is the next-cycle value, so the
  // frame_start cycle (both counters at 0) already runs on the new ratio.
  always_comb begin
    shd_bclk_d = load ? div_bclk : shd_bclk_q;
    shd_lr_d   = load ? div_lr   : shd_lr_q;
    apply      = !enable || frame_start;
    act_bclk_d = apply ? shd_bclk_q : act_bclk_q;
    act_lr_d   = apply ? shd_lr_q   : act_lr_q;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      shd_bclk_q <= DIV_W'(DEF_BCLK_DIV);
      act_bclk_q <= DIV_W'(DEF_BCLK_DIV);
      shd_lr_q   <= LR_W'(DEF_LR_DIV);
      act_lr_q   <= LR_W'(DEF_LR_DIV);
    end else begin
      shd_bclk_q <= shd_bclk_d;
      act_bclk_q <= act_bclk_d;
      shd_lr_q   <= shd_lr_d;
      act_lr_q   <= act_lr_d;
    end
  end

  clk_div_core #(.W(DIV_W), .MIN_RATIO(AC_MIN_BCLK_DIV), .TOGGLE(1'b0)) u_bclk (
    .clk_in    (clk_in),
    .reset     (reset),
    .run       (enable),
    .advance   (1'b1),
    .ratio     (act_bclk_d),
    .level     (bclk_out),
    .rise      (bclk_rise),
    .fall      (bclk_fall),
    .fall_next (bclk_fall_next)
  );

  clk_div_core #(.W(LR_W), .MIN_RATIO(AC_MIN_LR_DIV), .TOGGLE(1'b1)) u_lr (
    .clk_in    (clk_in),
    .reset     (reset),
    .run       (enable),
    .advance   (bclk_fall_next),
    .ratio     (act_lr_d),
    .level     (lrclk_out),
    .rise      (lr_rise_unused),
    .fall      (frame_start),
    .fall_next (lr_fall_next_unused)
  );
endmodule
